// File: rtl/mux32_arbiter_pkg.sv
// Shared constants, FSM state type and grant helper for the 32-way round-robin arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package mux32_arbiter_pkg;

    localparam int NUM_REQ = 32;
    localparam int SEL_W   = 5;
    localparam int CNT_W   = 8;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_e;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        return NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux32_arbiter_rr_pick32.sv
// Round-robin winner search: first asserted req at or above ptr, wrapping 31 -> 0.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is asserted.
module rr_pick32
    import mux32_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_W-1:0]     off;

    always_comb begin
        // Rotate so ptr lands at bit 0; the lowest set bit is then the winner's offset.
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        idx = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter for 32 requesters driving the select of an external 32:1 mux.
// Latency: one cycle req -> valid; release and re-grant happen on the same edge.
// Backpressure: grant held until done, request drop, or HOLD_MAX cycles (timeout pulse).
module mux32_arbiter
    import mux32_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   select,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;

    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_any;
    logic               cur_req;
    logic               hold_hit;
    logic               release_evt;

    assign cur_req     = req[sel_q];
    assign hold_hit    = (cnt_q == HOLD_LAST);
    assign release_evt = (state_q == S_GRANT) && (done || !cur_req || hold_hit);

    // While granting, search from one past the grantee so a release re-arbitrates in the same edge.
    assign pick_ptr = (state_q == S_GRANT) ? sel_q + SEL_W'(1) : ptr_q;

    rr_pick32 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    state_d = S_GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (release_evt) begin
                    ptr_d = pick_ptr;
                    // done wins over the hold limit, so a coincident done never flags a timeout.
                    to_d  = hold_hit && !done && cur_req;
                    if (pick_any) begin
                        sel_d = pick_idx;
                        cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign valid   = (state_q == S_GRANT);
    assign select  = sel_q;
    assign grant   = valid ? sel_onehot(sel_q) : '0;
    assign timeout = to_q;

endmodule

// File: tb/tb_mux32_arbiter.sv
// Directed bench for mux32_arbiter with a cycle-level behavioural model and literal checkpoints.
module tb_mux32_arbiter;

    localparam int HM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req = 32'h0000_0010;
    logic        done = 1'b0;
    logic [4:0]  select;
    logic [31:0] grant;
    logic        valid;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // model state: grant active, grantee, next-priority index, cycles grant has been shown, timeout pulse
    bit m_valid = 1'b0;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    mux32_arbiter #(.HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .select  (select),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [31:0] r, input int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return (p + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit to_n;
        bit hit;
        to_n = 1'b0;
        if (rst) begin
            m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_held = 0;
        end else if (!m_valid) begin
            if (req != 0) begin
                m_sel = pick(req, m_ptr); m_valid = 1'b1; m_held = 1;
            end
        end else begin
            hit = (m_held == HM);
            if (done || !req[m_sel] || hit) begin
                to_n  = hit && !done && req[m_sel];
                m_ptr = (m_sel + 1) % 32;
                if (req != 0) begin
                    m_sel = pick(req, m_ptr); m_held = 1;
                end else begin
                    m_valid = 1'b0;
                end
            end else begin
                m_held++;
            end
        end
        m_to = to_n;
    endtask

    // One clock: advance the model on the edge, then compare all outputs 1 time unit later.
    task automatic tick();
        logic [31:0] m_grant;
        @(posedge clk);
        model_step();
        #1;
        m_grant = m_valid ? (32'h1 << m_sel) : 32'h0;
        chk("model_valid",   {31'b0, valid},   {31'b0, m_valid});
        chk("model_select",  {27'b0, select},  32'(m_sel));
        chk("model_grant",   grant,            m_grant);
        chk("model_timeout", {31'b0, timeout}, {31'b0, m_to});
    endtask

    int          exp_c_sel [9] = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
    bit          exp_c_to  [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    logic [31:0] g_req     [8] = '{32'h0000_00F0, 32'h0000_00F0, 32'h8000_0000, 32'h0001_0100,
                                   32'h0000_0000, 32'hAAAA_5555, 32'h0000_0002, 32'hFFFF_FFFF};
    bit          g_done    [8] = '{1, 0, 0, 1, 0, 0, 1, 0};

    initial begin
        // reset state and first grant from ptr=0
        tick(); tick();
        chk("rst_valid",   {31'b0, valid}, 32'd0);
        chk("rst_select",  {27'b0, select}, 32'd0);
        chk("rst_grant",   grant, 32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        rst = 1'b0;
        tick();
        chk("first_valid",  {31'b0, valid}, 32'd1);
        chk("first_select", {27'b0, select}, 32'd4);
        chk("first_grant",  grant, 32'h0000_0010);
        // sole requester hits the hold limit and is re-granted with a timeout pulse
        repeat (HM) tick();
        chk("sole_regrant_select",  {27'b0, select}, 32'd4);
        chk("sole_regrant_timeout", {31'b0, timeout}, 32'd1);

        // request drop releases to idle; select is retained while idle
        req = 32'h0000_0080;
        tick();
        chk("move7_select",  {27'b0, select}, 32'd7);
        chk("move7_timeout", {31'b0, timeout}, 32'd0);
        req = 32'h0;
        tick();
        chk("drop_valid",   {31'b0, valid}, 32'd0);
        chk("drop_grant",   grant, 32'd0);
        chk("drop_timeout", {31'b0, timeout}, 32'd0);
        tick();
        chk("idle_select_kept", {27'b0, select}, 32'd7);
        req = 32'h0000_0080;
        tick();
        chk("regrant7_valid",  {31'b0, valid}, 32'd1);
        chk("regrant7_select", {27'b0, select}, 32'd7);

        // hold limit alternation between requesters 0 and 3
        req = 32'h0000_0009;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("hold_sel_%0d", k), {27'b0, select}, 32'(exp_c_sel[k]));
            chk($sformatf("hold_to_%0d", k),  {31'b0, timeout}, {31'b0, exp_c_to[k]});
        end

        // done on every grant with all requesting walks 1..31, 0, 1
        req  = 32'hFFFF_FFFF;
        done = 1'b1;
        for (int k = 0; k < 33; k++) begin
            tick();
            chk($sformatf("walk_sel_%0d", k), {27'b0, select}, 32'((k + 1) % 32));
            chk($sformatf("walk_valid_%0d", k), {31'b0, valid}, 32'd1);
        end

        // wrap from 31 back to 0
        done = 1'b0;
        req  = 32'h4000_0000;
        tick();
        chk("wrap_sel30", {27'b0, select}, 32'd30);
        req = 32'h8000_0001;
        tick();
        chk("wrap_sel31", {27'b0, select}, 32'd31);
        done = 1'b1;
        tick();
        chk("wrap_sel0", {27'b0, select}, 32'd0);
        done = 1'b0;

        // asynchronous reset mid-grant
        req = 32'h0000_1000;
        tick();
        chk("pre_rst_select", {27'b0, select}, 32'd12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, valid}, 32'd0);
        chk("async_rst_grant", grant, 32'd0);
        req = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_select", {27'b0, select}, 32'd0);
        chk("post_rst_valid",  {31'b0, valid}, 32'd1);

        // assorted patterns checked against the model only
        for (int k = 0; k < 8; k++) begin
            req  = g_req[k];
            done = g_done[k];
            repeat (3) tick();
        end
        req  = 32'h0;
        done = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
